// File: rtl/arith_result_checker_if.sv
// Expected-word and observed-word valid/ready channels
// between the stimulus/DUT side and the result checker.
interface arith_result_checker_if #(
    parameter int WIDTH = 5
);
    logic             exp_valid;
    logic [WIDTH-1:0] exp_data;
    logic             exp_ready;
    logic             dut_valid;
    logic [WIDTH-1:0] dut_data;
    logic             dut_ready;

    modport master (
        output exp_valid, exp_data,
        output dut_valid, dut_data,
        input  exp_ready, dut_ready
    );

    modport slave (
        input  exp_valid, exp_data,
        input  dut_valid, dut_data,
        output exp_ready, dut_ready
    );
endinterface

// File: rtl/arith_result_checker.sv
// Flow-controlled scoreboard for the 4-bit add/sub datapath:
// expected words queue in a FIFO, observed words pop and compare.
module arith_result_checker #(
    parameter int WIDTH       = 5,
    parameter int DEPTH       = 4,
    parameter int CNT_W       = 12,
    parameter int NUM_VECTORS = 2048
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    arith_result_checker_if.slave  bus,
    output logic                   busy,
    output logic                   done,
    output logic [CNT_W-1:0]       pass_count,
    output logic [CNT_W-1:0]       err_count,
    output logic                   err_seen,
    output logic [CNT_W-1:0]       first_err_idx,
    output logic [WIDTH-1:0]       first_err_exp,
    output logic [WIDTH-1:0]       first_err_got
);
    localparam int PW = $clog2(DEPTH);
    localparam int TW = CNT_W + 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic [PW:0]      occ;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] head;
    logic [TW-1:0]    total;
    logic             push;
    logic             pop;
    logic             match;
    logic             last;

    function automatic logic [CNT_W-1:0] sat_inc(
        input logic [CNT_W-1:0] v
    );
        return (&v) ? v : v + 1'b1;
    endfunction

    // Readies come from registered state only, so a full FIFO
    // refuses a push even while a pop frees a slot.
    assign bus.exp_ready = (state == RUN) &&
                           (occ < (PW+1)'(DEPTH));
    assign bus.dut_ready = (state == RUN) && (occ != '0);

    assign push  = bus.exp_valid && bus.exp_ready;
    assign pop   = bus.dut_valid && bus.dut_ready;
    assign head  = mem[rd_ptr];
    assign match = (bus.dut_data == head);
    assign total = {1'b0, pass_count} + {1'b0, err_count};
    assign last  = pop && (total + TW'(1) == TW'(NUM_VECTORS));

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= bus.exp_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            rd_ptr        <= '0;
            wr_ptr        <= '0;
            occ           <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            pass_count    <= '0;
            err_count     <= '0;
            err_seen      <= 1'b0;
            first_err_idx <= '0;
            first_err_exp <= '0;
            first_err_got <= '0;
        end else begin
            unique case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state         <= RUN;
                        busy          <= 1'b1;
                        done          <= 1'b0;
                        rd_ptr        <= '0;
                        wr_ptr        <= '0;
                        occ           <= '0;
                        pass_count    <= '0;
                        err_count     <= '0;
                        err_seen      <= 1'b0;
                        first_err_idx <= '0;
                        first_err_exp <= '0;
                        first_err_got <= '0;
                    end
                end
                RUN: begin
                    if (push) wr_ptr <= wr_ptr + 1'b1;
                    if (pop)  rd_ptr <= rd_ptr + 1'b1;
                    unique case ({push, pop})
                        2'b10:   occ <= occ + 1'b1;
                        2'b01:   occ <= occ - 1'b1;
                        default: occ <= occ;
                    endcase
                    if (pop) begin
                        if (match) begin
                            pass_count <= sat_inc(pass_count);
                        end else begin
                            err_count <= sat_inc(err_count);
                            if (!err_seen) begin
                                err_seen      <= 1'b1;
                                first_err_idx <= total[CNT_W-1:0];
                                first_err_exp <= head;
                                first_err_got <= bus.dut_data;
                            end
                        end
                    end
                    if (last) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_arith_result_checker.sv
// Directed bench for arith_result_checker with a 4-vector run
// length; expectations are hand-computed per step.
module tb_arith_result_checker;
    localparam int WIDTH = 5;
    localparam int CNT_W = 12;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] pass_count;
    logic [CNT_W-1:0] err_count;
    logic             err_seen;
    logic [CNT_W-1:0] first_err_idx;
    logic [WIDTH-1:0] first_err_exp;
    logic [WIDTH-1:0] first_err_got;

    int checks = 0;
    int errors = 0;

    arith_result_checker_if #(.WIDTH(WIDTH)) bus ();

    arith_result_checker #(
        .WIDTH(WIDTH),
        .DEPTH(4),
        .CNT_W(CNT_W),
        .NUM_VECTORS(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .bus(bus),
        .busy(busy),
        .done(done),
        .pass_count(pass_count),
        .err_count(err_count),
        .err_seen(err_seen),
        .first_err_idx(first_err_idx),
        .first_err_exp(first_err_exp),
        .first_err_got(first_err_got)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h",
                   tag, got, exp);
        end
    endtask

    task automatic push(input logic [WIDTH-1:0] d);
        bus.exp_valid = 1'b1;
        bus.exp_data  = d;
        tick();
        bus.exp_valid = 1'b0;
    endtask

    task automatic give(input logic [WIDTH-1:0] d);
        bus.dut_valid = 1'b1;
        bus.dut_data  = d;
        tick();
        bus.dut_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        rst           = 1'b1;
        start         = 1'b0;
        bus.exp_valid = 1'b0;
        bus.exp_data  = '0;
        bus.dut_valid = 1'b0;
        bus.dut_data  = '0;
        tick();
        tick();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_exp_ready", bus.exp_ready, 0);
        chk("rst_dut_ready", bus.dut_ready, 0);
        chk("rst_pass", pass_count, 0);
        chk("rst_err", err_count, 0);
        chk("rst_err_seen", err_seen, 0);
        chk("rst_idx", first_err_idx, 0);

        // Reset mid-cycle with three words queued
        rst = 1'b0;
        pulse_start();
        chk("a_busy", busy, 1);
        chk("a_exp_ready", bus.exp_ready, 1);
        push(5'h01);
        push(5'h02);
        push(5'h03);
        chk("a_dut_ready_occ3", bus.dut_ready, 1);
        #3 rst = 1'b1;
        #1;
        chk("a_async_busy", busy, 0);
        chk("a_async_exp_ready", bus.exp_ready, 0);
        chk("a_async_dut_ready", bus.dut_ready, 0);
        chk("a_async_pass", pass_count, 0);
        tick();
        rst = 1'b0;
        pulse_start();
        chk("a_restart_busy", busy, 1);
        chk("a_restart_exp_ready", bus.exp_ready, 1);
        chk("a_restart_dut_ready", bus.dut_ready, 0);

        // Run 1: four matching words including carry-only
        push(5'h0A);
        push(5'h1F);
        push(5'h00);
        push(5'h10);
        chk("b_full_exp_ready", bus.exp_ready, 0);
        give(5'h0A);
        chk("b_pass1", pass_count, 1);
        give(5'h1F);
        give(5'h00);
        chk("b_pass3", pass_count, 3);
        chk("b_not_done3", done, 0);
        give(5'h10);
        chk("b_pass4", pass_count, 4);
        chk("b_err", err_count, 0);
        chk("b_err_seen", err_seen, 0);
        chk("b_done", done, 1);
        chk("b_busy", busy, 0);
        chk("b_exp_ready", bus.exp_ready, 0);
        bus.exp_valid = 1'b1;
        bus.dut_valid = 1'b1;
        tick();
        bus.exp_valid = 1'b0;
        bus.dut_valid = 1'b0;
        chk("b_done_hold_pass", pass_count, 4);
        chk("b_done_hold", done, 1);

        // Run 2: full FIFO refuses push during a pop
        pulse_start();
        chk("d_pass_clr", pass_count, 0);
        chk("d_busy", busy, 1);
        chk("d_done", done, 0);
        push(5'h01);
        push(5'h02);
        push(5'h03);
        chk("d_exp_ready_occ3", bus.exp_ready, 1);
        push(5'h04);
        chk("d_exp_ready_occ4", bus.exp_ready, 0);
        bus.exp_valid = 1'b1;
        bus.exp_data  = 5'h05;
        bus.dut_valid = 1'b1;
        bus.dut_data  = 5'h01;
        tick();
        bus.dut_valid = 1'b0;
        chk("d_pop_pass", pass_count, 1);
        chk("d_exp_ready_occ3b", bus.exp_ready, 1);
        tick();
        bus.exp_valid = 1'b0;
        chk("d_refill_exp_ready", bus.exp_ready, 0);
        give(5'h02);
        give(5'h03);
        give(5'h04);
        chk("d_pass4", pass_count, 4);
        chk("d_err0", err_count, 0);
        chk("d_done", done, 1);

        // Run 3: leftover word discarded, mismatches captured
        pulse_start();
        chk("c_dut_ready_empty", bus.dut_ready, 0);
        chk("c_exp_ready", bus.exp_ready, 1);
        push(5'h13);
        push(5'h05);
        push(5'h07);
        give(5'h13);
        give(5'h15);
        give(5'h06);
        chk("c_pass", pass_count, 1);
        chk("c_err", err_count, 2);
        chk("c_err_seen", err_seen, 1);
        chk("c_idx", first_err_idx, 1);
        chk("c_exp", first_err_exp, 5'h05);
        chk("c_got", first_err_got, 5'h15);
        chk("c_dut_ready_drained", bus.dut_ready, 0);

        // Empty FIFO stalls the DUT side; no bypass
        bus.dut_valid = 1'b1;
        bus.dut_data  = 5'h08;
        tick();
        chk("e_dut_ready_empty", bus.dut_ready, 0);
        chk("e_pass_hold", pass_count, 1);
        chk("e_err_hold", err_count, 2);
        push(5'h08);
        chk("e_dut_ready_n1", bus.dut_ready, 1);
        chk("e_pass_n1", pass_count, 1);
        tick();
        bus.dut_valid = 1'b0;
        chk("e_pass_n2", pass_count, 2);
        chk("e_err_n2", err_count, 2);
        chk("e_done", done, 1);
        chk("e_idx_hold", first_err_idx, 1);

        // Run 4: restart from DONE clears; start in RUN ignored
        pulse_start();
        chk("f_pass", pass_count, 0);
        chk("f_err", err_count, 0);
        chk("f_err_seen", err_seen, 0);
        chk("f_idx", first_err_idx, 0);
        chk("f_exp", first_err_exp, 0);
        chk("f_got", first_err_got, 0);
        chk("f_dut_ready", bus.dut_ready, 0);
        chk("f_busy", busy, 1);
        push(5'h0A);
        chk("f_dut_ready_q", bus.dut_ready, 1);
        pulse_start();
        chk("f_rs_busy", busy, 1);
        chk("f_rs_dut_ready", bus.dut_ready, 1);
        give(5'h0B);
        chk("f_rs_err", err_count, 1);
        chk("f_rs_idx", first_err_idx, 0);
        chk("f_rs_exp", first_err_exp, 5'h0A);
        chk("f_rs_got", first_err_got, 5'h0B);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end
endmodule

// File: doc/arith_result_checker.md
Name: arith_result_checker

Overview:
- Sequential response-side checker for the 4-bit add/subtract datapath.
- The stimulus generator pushes expected {carry, sum} words into a small internal FIFO.
- The DUT side presents observed {carry, sum} words over a valid/ready handshake. Each observed word is compared in order against the oldest expected word.
- Reports pass/error counts, first-error capture and run completion. It replaces the free-running compare-every-negedge analyzer with a clocked, flow-controlled scoreboard.

Parameters:
WIDTH, 5, result width: bit 4 = carry out, bits 3:0 = sum
DEPTH, 4, expected-word FIFO depth; power of two, at least 2
CNT_W, 12, width of the pass/error/index counters
NUM_VECTORS, 2048, comparisons per run before done

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  single-cycle pulse; begins a run from IDLE or DONE
exp_valid  input  1  expected word offered
exp_data  input  WIDTH  expected {cout, sum}
exp_ready  output  1  checker accepts expected word this cycle
dut_valid  input  1  observed word offered
dut_data  input  WIDTH  observed {cout, sum}
dut_ready  output  1  checker accepts observed word this cycle
busy  output  1  state is RUN
done  output  1  state is DONE
pass_count  output  CNT_W  matched comparisons this run
err_count  output  CNT_W  mismatched comparisons this run
err_seen  output  1  at least one mismatch this run
first_err_idx  output  CNT_W  comparison index (0-based) of first mismatch
first_err_exp  output  WIDTH  expected word at first mismatch
first_err_got  output  WIDTH  observed word at first mismatch

Behaviour:
- Reset, async, takes effect immediately:
  - state = IDLE; FIFO empty (rd_ptr = wr_ptr = occupancy = 0).
  - All counters and first_err_* = 0; err_seen = 0, busy = 0, done = 0.
  - exp_ready = 0, dut_ready = 0.
  - Reset mid-run abandons the run completely; no partial results are retained.
- FSM:
  - IDLE --start--> RUN: on entry, clear counters, err_seen, first_err_* and the FIFO.
  - RUN --checked count reaches NUM_VECTORS--> DONE.
  - DONE --start--> RUN: same clearing as from IDLE.
  - start while in RUN is ignored.
- Handshakes, all combinational from registered state:
  - exp_ready = RUN and occupancy < DEPTH.
  - dut_ready = RUN and occupancy > 0.
  - There is no bypass: an expected word pushed in cycle N is first comparable in cycle N+1.
- Push and pop:
  - Push when exp_valid and exp_ready.
  - Pop when dut_valid and dut_ready.
  - Push and pop in the same cycle leave occupancy unchanged; both pointers advance and wrap modulo DEPTH.
  - When full, a push is refused even if a pop occurs in the same cycle, because exp_ready depends only on registered occupancy.
- Compare: on a pop, compare dut_data against the FIFO head, full WIDTH, including carry.
  - Match: pass_count increments on the next rising edge.
  - Mismatch: err_count increments on the next rising edge. If err_seen = 0, also load first_err_idx = pass_count + err_count (pre-increment), first_err_exp = head and first_err_got = dut_data, and set err_seen.
  - Latency from handshake to counter update is 1 cycle.
- Completion:
  - Transition to DONE on the same edge that makes pass_count + err_count = NUM_VECTORS. done rises that edge; busy falls.
  - Words remaining in the FIFO at DONE are discarded when the next run starts.
  - In DONE, exp_ready = dut_ready = 0 and all outputs hold.
- Outside RUN, exp_valid and dut_valid are ignored and have no effect on any state.
- Counters saturate at 2^CNT_W - 1. This is unreachable with the defaults.
- All outputs are registered except exp_ready and dut_ready.

Test Plan:
- Reset asserted mid-cycle with occupancy 3 -> immediately busy = 0, exp_ready = 0, counts 0; after release, start -> busy = 1 next cycle, exp_ready = 1.
- NUM_VECTORS = 4; push 5'h0A, 5'h1F, 5'h00, 5'h10; DUT returns the same four -> pass_count = 4, err_count = 0, err_seen = 0, done = 1 one cycle after the 4th dut handshake.
- Push 5'h13, 5'h05, 5'h07; DUT returns 5'h13, 5'h15, 5'h06 -> pass_count = 1, err_count = 2, first_err_idx = 1, first_err_exp = 5'h05, first_err_got = 5'h15.
- Push 4 words without DUT activity -> exp_ready = 0 at occupancy 4. Then hold exp_valid with dut_valid = 1 -> push refused that cycle and accepted the next; occupancy returns to 4.
- dut_valid = 1 with the FIFO empty -> dut_ready = 0 and no count changes. Push 5'h08 at cycle N -> dut_ready = 1 at N+1; pass_count increments at N+2.
- From DONE with err_seen = 1, pulse start -> counts, err_seen and first_err_* cleared next cycle, FIFO empty; start pulsed again during RUN -> no effect.
